memory_stage: RTL and testbench

- Pipeline stage directly downstream of Execute; consumes the execute→memory payload and produces the memory→writeback payload.
- Issues load/store requests on a single-outstanding data-memory bus with variable latency.
- Performs byte-lane alignment, store strobes, load extraction and sign/zero extension, and misaligned/range fault detection.
- Raises a stall request to the hazard unit while an access is in flight.

---
 rtl/memory_stage_if.sv | 22 ++
 rtl/memory_stage.sv | 265 ++++++++++++++++++++++++++
 tb/tb_memory_stage.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_if.sv
// Data-memory bus between the memory stage and the data memory.
// Single outstanding request; dmemReady accepts, dmemRvalid returns load data.
interface memory_stage_if;
    logic        dmemReq;
    logic        dmemWe;
    logic [31:0] dmemAddr;
    logic [31:0] dmemWdata;
    logic [3:0]  dmemWstrb;
    logic        dmemReady;
    logic        dmemRvalid;
    logic [31:0] dmemRdata;

    modport master (
        output dmemReq, dmemWe, dmemAddr, dmemWdata, dmemWstrb,
        input  dmemReady, dmemRvalid, dmemRdata
    );

    modport slave (
        input  dmemReq, dmemWe, dmemAddr, dmemWdata, dmemWstrb,
        output dmemReady, dmemRvalid, dmemRdata
    );
endinterface

// File: rtl/memory_stage.sv
// Memory pipeline stage: load/store issue on a single-outstanding bus,
// lane alignment, load extension and misaligned/range fault detection.
module memory_stage #(
    parameter logic [31:0] DMEM_BASE = 32'h0001_0000,
    parameter logic [31:0] DMEM_SIZE = 32'h0001_0000
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           inValid,
    input  logic [31:0]    inResult,
    input  logic [31:0]    inStoreData,
    input  logic           inReadEnable,
    input  logic           inWriteEnable,
    input  logic [1:0]     inWidth,
    input  logic           inSigned,
    input  logic [4:0]     inDestReg,
    input  logic [31:0]    inProgramCounter,
    input  logic           stall,
    input  logic           flush,
    memory_stage_if.master dmem,
    output logic           stallRequest,
    output logic           outValid,
    output logic [4:0]     outDestReg,
    output logic [31:0]    outData,
    output logic [31:0]    outProgramCounter,
    output logic [1:0]     outFault
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    localparam logic [32:0] DMEM_END = {1'b0, DMEM_BASE} + {1'b0, DMEM_SIZE};

    function automatic logic [31:0] lane_data(
        input logic [31:0] d,
        input logic [1:0]  wd
    );
        logic [31:0] r;
        unique case (wd)
            2'd0:    r = {4{d[7:0]}};
            2'd1:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] lane_strb(
        input logic [1:0] off,
        input logic [1:0] wd
    );
        logic [3:0] r;
        unique case (wd)
            2'd0:    r = 4'b0001 << off;
            2'd1:    r = 4'b0011 << off;
            default: r = 4'hF;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extract(
        input logic [31:0] w,
        input logic [1:0]  off,
        input logic [1:0]  wd,
        input logic        sg
    );
        logic [31:0] sh;
        logic [31:0] r;
        sh = w >> {off, 3'b000};
        unique case (wd)
            2'd0:    r = {{24{sg & sh[7]}}, sh[7:0]};
            2'd1:    r = {{16{sg & sh[15]}}, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        we_q, we_d;
    logic [1:0]  width_q, width_d;
    logic        sgn_q, sgn_d;
    logic [4:0]  dest_q, dest_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rdata_q, rdata_d;
    logic        acc_q, acc_d;
    logic        got_q, got_d;
    logic        kill_q, kill_d;
    logic        out_valid_q, out_valid_d;
    logic [4:0]  out_dest_q, out_dest_d;
    logic [31:0] out_data_q, out_data_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [1:0]  out_fault_q, out_fault_d;

    logic        mem_op;
    logic        misal;
    logic        oor;
    logic [1:0]  fault;
    logic        launch;
    logic        req;

    always_comb begin
        mem_op = inValid & (inReadEnable | inWriteEnable);
        misal  = (inWidth == 2'd3)
               | ((inWidth == 2'd1) & inResult[0])
               | ((inWidth == 2'd2) & (|inResult[1:0]));
        oor    = (inResult < DMEM_BASE) | ({1'b0, inResult} >= DMEM_END);
        if (!mem_op)
            fault = 2'd0;
        else if (misal)
            fault = inWriteEnable ? 2'd2 : 2'd1;
        else if (oor)
            fault = 2'd3;
        else
            fault = 2'd0;
        launch = ~reset & (state_q == IDLE) & mem_op & (fault == 2'd0) & ~flush;
        req    = launch | (~reset & (state_q == REQ) & ~acc_q);
    end

    // In the launch cycle the bus is driven straight from the inputs.
    assign dmem.dmemReq   = req;
    assign dmem.dmemWe    = req & (launch ? inWriteEnable : we_q);
    assign dmem.dmemAddr  = !req ? 32'h0 :
                            launch ? {inResult[31:2], 2'b00} :
                                     {addr_q[31:2], 2'b00};
    assign dmem.dmemWdata = !req ? 32'h0 :
                            launch ? lane_data(inStoreData, inWidth) : wdata_q;
    assign dmem.dmemWstrb = !req ? 4'h0 :
                            launch ? lane_strb(inResult[1:0], inWidth) : wstrb_q;

    assign stallRequest = ~reset & (launch
                        | (state_q == REQ)
                        | (state_q == WAIT)
                        | ((state_q == DONE) & stall));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        we_d        = we_q;
        width_d     = width_q;
        sgn_d       = sgn_q;
        dest_d      = dest_q;
        pc_d        = pc_q;
        rdata_d     = rdata_q;
        acc_d       = acc_q;
        got_d       = got_q;
        kill_d      = kill_q;
        out_valid_d = (stall & ~flush) ? out_valid_q : 1'b0;
        out_dest_d  = out_dest_q;
        out_data_d  = out_data_q;
        out_pc_d    = out_pc_q;
        out_fault_d = out_fault_q;

        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = REQ;
                    addr_d  = inResult;
                    wdata_d = lane_data(inStoreData, inWidth);
                    wstrb_d = lane_strb(inResult[1:0], inWidth);
                    we_d    = inWriteEnable;
                    width_d = inWidth;
                    sgn_d   = inSigned;
                    dest_d  = inDestReg;
                    pc_d    = inProgramCounter;
                    kill_d  = 1'b0;
                    acc_d   = dmem.dmemReady;
                    got_d   = dmem.dmemReady & dmem.dmemRvalid & ~inWriteEnable;
                    rdata_d = extract(dmem.dmemRdata, inResult[1:0], inWidth, inSigned);
                end else if (!flush && !stall && inValid) begin
                    out_valid_d = 1'b1;
                    out_dest_d  = inDestReg;
                    out_data_d  = inResult;
                    out_pc_d    = inProgramCounter;
                    out_fault_d = fault;
                end
            end
            REQ: begin
                kill_d = kill_q | flush;
                if (acc_q | dmem.dmemReady) begin
                    acc_d = 1'b1;
                    if (we_q || got_q) begin
                        state_d = DONE;
                    end else if (dmem.dmemRvalid) begin
                        got_d   = 1'b1;
                        rdata_d = extract(dmem.dmemRdata, addr_q[1:0], width_q, sgn_q);
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                kill_d = kill_q | flush;
                if (dmem.dmemRvalid) begin
                    rdata_d = extract(dmem.dmemRdata, addr_q[1:0], width_q, sgn_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!stall) begin
                    state_d     = IDLE;
                    out_valid_d = ~(kill_q | flush);
                    out_dest_d  = dest_q;
                    out_data_d  = we_q ? addr_q : rdata_q;
                    out_pc_d    = pc_q;
                    out_fault_d = 2'd0;
                end else begin
                    kill_d = kill_q | flush;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            we_q        <= 1'b0;
            width_q     <= '0;
            sgn_q       <= 1'b0;
            dest_q      <= '0;
            pc_q        <= '0;
            rdata_q     <= '0;
            acc_q       <= 1'b0;
            got_q       <= 1'b0;
            kill_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_dest_q  <= '0;
            out_data_q  <= '0;
            out_pc_q    <= '0;
            out_fault_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            we_q        <= we_d;
            width_q     <= width_d;
            sgn_q       <= sgn_d;
            dest_q      <= dest_d;
            pc_q        <= pc_d;
            rdata_q     <= rdata_d;
            acc_q       <= acc_d;
            got_q       <= got_d;
            kill_q      <= kill_d;
            out_valid_q <= out_valid_d;
            out_dest_q  <= out_dest_d;
            out_data_q  <= out_data_d;
            out_pc_q    <= out_pc_d;
            out_fault_q <= out_fault_d;
        end
    end

    assign outValid          = out_valid_q;
    assign outDestReg        = out_dest_q;
    assign outData           = out_data_q;
    assign outProgramCounter = out_pc_q;
    assign outFault          = out_fault_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed cases plus random ops
// checked against a behavioural model of the stage.
module tb_memory_stage;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] SIZE = 32'h0001_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        inValid;
    logic [31:0] inResult;
    logic [31:0] inStoreData;
    logic        inReadEnable;
    logic        inWriteEnable;
    logic [1:0]  inWidth;
    logic        inSigned;
    logic [4:0]  inDestReg;
    logic [31:0] inProgramCounter;
    logic        stall;
    logic        flush;
    logic        stallRequest;
    logic        outValid;
    logic [4:0]  outDestReg;
    logic [31:0] outData;
    logic [31:0] outProgramCounter;
    logic [1:0]  outFault;

    memory_stage_if bus ();

    memory_stage dut (
        .clock             (clock),
        .reset             (reset),
        .inValid           (inValid),
        .inResult          (inResult),
        .inStoreData       (inStoreData),
        .inReadEnable      (inReadEnable),
        .inWriteEnable     (inWriteEnable),
        .inWidth           (inWidth),
        .inSigned          (inSigned),
        .inDestReg         (inDestReg),
        .inProgramCounter  (inProgramCounter),
        .stall             (stall),
        .flush             (flush),
        .dmem              (bus),
        .stallRequest      (stallRequest),
        .outValid          (outValid),
        .outDestReg        (outDestReg),
        .outData           (outData),
        .outProgramCounter (outProgramCounter),
        .outFault          (outFault)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        valid;
        logic        re;
        logic        we;
        logic [1:0]  width;
        logic        sgn;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] pc;
    } op_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
        logic [1:0]  fault;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fault(input op_t o);
        bit misal;
        if (!(o.valid && (o.re || o.we))) return 2'd0;
        misal = (o.width == 3) || (o.width == 1 && o.addr % 2 != 0)
             || (o.width == 2 && o.addr % 4 != 0);
        if (misal) return o.we ? 2'd2 : 2'd1;
        if (longint'(o.addr) < longint'(BASE) ||
            longint'(o.addr) >= longint'(BASE) + longint'(SIZE)) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input op_t o);
        logic [31:0] v;
        v = w >> (8 * (o.addr % 4));
        if (o.width == 0) begin
            v = v % 256;
            if (o.sgn && v >= 128) v = v - 256;
        end else if (o.width == 1) begin
            v = v % 65536;
            if (o.sgn && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_wdata(input op_t o);
        if (o.width == 0) return (o.sdata % 256) * 32'h0101_0101;
        if (o.width == 1) return (o.sdata % 65536) * 32'h0001_0001;
        return o.sdata;
    endfunction

    function automatic logic [3:0] ref_wstrb(input op_t o);
        int bytes;
        bytes = 1 << o.width;
        return 4'(((1 << bytes) - 1) << (o.addr % 4));
    endfunction

    function automatic op_t mk(input bit v, input bit re, input bit we,
                               input logic [1:0] wd, input bit sg,
                               input logic [31:0] a, input logic [31:0] d);
        op_t o;
        o.valid = v; o.re = re; o.we = we; o.width = wd; o.sgn = sg;
        o.addr = a; o.sdata = d;
        o.rd = 5'($urandom);
        o.pc = $urandom & 32'hFFFF_FFFC;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int  t;
        int  r;
        t = $urandom % 3;
        o = mk(($urandom % 10) != 0, t == 1, t == 2,
               ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3),
               1'($urandom), 32'h0, $urandom);
        r = $urandom % 10;
        if (r < 7) begin
            o.addr = BASE + ($urandom % SIZE);
            if (o.width == 1) o.addr = o.addr & 32'hFFFF_FFFE;
            if (o.width == 2) o.addr = o.addr & 32'hFFFF_FFFC;
        end else if (r == 7) begin
            o.addr = BASE + ($urandom % SIZE);
        end else begin
            o.addr = $urandom;
        end
        return o;
    endfunction

    task automatic drive_op(input op_t o);
        inValid          = o.valid;
        inResult         = o.addr;
        inStoreData      = o.sdata;
        inReadEnable     = o.re;
        inWriteEnable    = o.we;
        inWidth          = o.width;
        inSigned         = o.sgn;
        inDestReg        = o.rd;
        inProgramCounter = o.pc;
    endtask

    task automatic drive_idle();
        op_t o;
        o = mk(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
        drive_op(o);
        stall = 0;
        flush = 0;
        bus.dmemReady  = 0;
        bus.dmemRvalid = 0;
        bus.dmemRdata  = 32'h0;
    endtask

    task automatic do_op(input op_t o, input int rdy_at, input int rv_after,
                         input int stall_len, input int flush_at,
                         input logic [31:0] rdata);
        logic [1:0] f;
        bit         legal;
        exp_t       e;
        int         a;
        int         d;
        int         dn;
        int         acc_k;
        bit         killed;
        bit         in_done;
        bit         exp_req;
        op_t        g;
        f = ref_fault(o);
        legal = o.valid && (o.re || o.we) && f == 0;
        if (!legal || flush_at == 0) begin
            if (legal) stall_len = 0;
            for (int k = 0; k < 100; k++) begin
                @(posedge clock); #1;
                drive_op(o);
                flush = (k == flush_at);
                stall = (k < stall_len) && !flush;
                bus.dmemReady  = 1'($urandom);
                bus.dmemRvalid = 1'($urandom);
                bus.dmemRdata  = $urandom;
                @(negedge clock);
                check("idle_stallreq", stallRequest, 0);
                check("idle_no_req", bus.dmemReq, 0);
                if (!stall) begin
                    if (!flush && o.valid) begin
                        e.rd = o.rd; e.data = o.addr; e.pc = o.pc; e.fault = f;
                        sbq.push_back(e);
                    end
                    return;
                end
            end
            check("idle_timeout", 1, 0);
            return;
        end
        a = -1; d = -1; dn = 0; killed = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clock); #1;
            if (k == 0) begin
                drive_op(o);
            end else begin
                g = rand_op();
                drive_op(g);
            end
            exp_req = (a < 0);
            bus.dmemReady = (a < 0) ? (k >= rdy_at) : 1'($urandom);
            acc_k = (a >= 0) ? a : (bus.dmemReady ? k : -1);
            bus.dmemRvalid = !o.we && acc_k >= 0 && d < 0 && k >= acc_k + rv_after;
            bus.dmemRdata  = bus.dmemRvalid ? rdata : $urandom;
            if (a < 0 && bus.dmemReady) a = k;
            if (bus.dmemRvalid || (o.we && a == k)) d = k;
            if (d >= 0) dn = (d + 1 > 2) ? d + 1 : 2;
            in_done = (d >= 0) && (k >= dn);
            stall = in_done && (k < dn + stall_len);
            flush = (k == flush_at) && !stall;
            if (flush) killed = 1;
            @(negedge clock);
            check("dmem_req", bus.dmemReq, exp_req);
            if (exp_req) begin
                check("dmem_addr", bus.dmemAddr, o.addr & 32'hFFFF_FFFC);
                check("dmem_we", bus.dmemWe, o.we);
                if (o.we) begin
                    check("dmem_wdata", bus.dmemWdata, ref_wdata(o));
                    check("dmem_wstrb", bus.dmemWstrb, ref_wstrb(o));
                end
            end
            check("stall_request", stallRequest, !(in_done && !stall));
            if (in_done && !stall) begin
                if (!killed) begin
                    e.rd = o.rd; e.pc = o.pc; e.fault = 2'd0;
                    e.data = o.we ? o.addr : ref_load(rdata, o);
                    sbq.push_back(e);
                end
                return;
            end
        end
        check("mem_timeout", 1, 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && outValid && !stall) begin
                if (sbq.size() == 0) begin
                    check("unexpected_out", {outFault, outData[29:0]}, 32'h0);
                    n_tests++;
                    n_fail++;
                    $display("FAIL out_valid: got 1 expected 0 at %0t", $time);
                end else begin
                    e = sbq.pop_front();
                    check("out_rd", outDestReg, e.rd);
                    check("out_data", outData, e.data);
                    check("out_pc", outProgramCounter, e.pc);
                    check("out_fault", outFault, e.fault);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        op_t o;
        op_t r;
        int  fa;
        int  sl;
        drive_idle();
        reset = 1;
        o = mk(1, 1, 0, 2'd2, 0, 32'h0001_0000, 32'h0);
        drive_op(o);
        bus.dmemReady = 1;
        bus.dmemRvalid = 1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_stallreq", stallRequest, 0);
        check("rst_req", bus.dmemReq, 0);
        check("rst_addr", bus.dmemAddr, 0);
        check("rst_valid", outValid, 0);
        check("rst_data", outData, 0);
        check("rst_fault", outFault, 0);
        @(posedge clock); #1;
        reset = 0;
        drive_idle();

        do_op(mk(1, 0, 1, 2'd2, 0, 32'h0001_0004, 32'hDEAD_BEEF), 2, 0, 0, -1, 0);
        do_op(mk(1, 1, 0, 2'd0, 1, 32'h0001_0003, 0), 1, 3, 0, -1, 32'h80FF_1234);
        do_op(mk(1, 1, 0, 2'd0, 0, 32'h0001_0003, 0), 1, 3, 0, -1, 32'h80FF_1234);
        do_op(mk(1, 0, 1, 2'd1, 0, 32'h0001_0002, 32'h1234_ABCD), 0, 0, 0, -1, 0);
        do_op(mk(1, 1, 0, 2'd1, 0, 32'h0001_0001, 0), 0, 0, 0, -1, 0);
        do_op(mk(1, 1, 0, 2'd2, 0, 32'h0003_0000, 0), 0, 0, 0, -1, 0);
        do_op(mk(1, 0, 0, 2'd0, 0, 32'h0000_0007, 0), 0, 0, 0, -1, 0);
        do_op(mk(1, 1, 0, 2'd2, 0, 32'h0001_0010, 0), 1, 3, 0, 2, 32'h1111_2222);
        do_op(mk(1, 1, 0, 2'd1, 1, 32'h0001_0012, 0), 1, 1, 0, -1, 32'h8001_7FFF);
        do_op(mk(1, 1, 0, 2'd2, 0, 32'h0001_0020, 0), 0, 0, 4, -1, 32'hCAFE_F00D);
        do_op(mk(1, 0, 1, 2'd2, 0, 32'h0001_0002, 32'h5), 0, 0, 0, -1, 0);
        do_op(mk(1, 1, 0, 2'd1, 0, 32'h0000_0001, 0), 0, 0, 0, -1, 0);
        do_op(mk(1, 1, 0, 2'd3, 0, 32'h0001_0000, 0), 0, 0, 0, -1, 0);
        do_op(mk(1, 1, 0, 2'd2, 0, 32'h0001_FFFC, 0), 2, 2, 0, -1, 32'h0BAD_CAFE);
        do_op(mk(1, 0, 1, 2'd2, 0, 32'h0002_0000, 32'h1), 0, 0, 0, -1, 0);
        do_op(mk(1, 1, 0, 2'd2, 0, 32'h0000_FFFC, 0), 0, 0, 0, -1, 0);
        do_op(mk(1, 0, 0, 2'd0, 0, 32'h0000_0009, 0), 0, 0, 0, 0, 0);
        do_op(mk(1, 0, 1, 2'd0, 0, 32'h0001_0101, 32'h77), 3, 0, 0, 1, 0);
        do_op(mk(1, 0, 0, 2'd0, 0, 32'h0000_00AB, 0), 0, 0, 3, -1, 0);

        o = mk(1, 1, 0, 2'd2, 0, 32'h0001_0040, 0);
        @(posedge clock); #1;
        drive_op(o);
        @(posedge clock); #1;
        drive_idle();
        bus.dmemReady = 1;
        @(posedge clock); #1;
        bus.dmemReady = 0;
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        bus.dmemRvalid = 1;
        bus.dmemRdata = 32'hFFFF_FFFF;
        @(negedge clock);
        check("wrst_stallreq", stallRequest, 0);
        check("wrst_req", bus.dmemReq, 0);
        check("wrst_valid", outValid, 0);
        check("wrst_data", outData, 0);
        check("wrst_fault", outFault, 0);
        @(posedge clock); #1;
        drive_idle();
        do_op(mk(1, 1, 0, 2'd0, 1, 32'h0001_0041, 0), 1, 1, 0, -1, 32'h0000_FE00);

        for (int i = 0; i < 300; i++) begin
            r  = rand_op();
            fa = ($urandom % 7 == 0) ? int'($urandom % 5) : -1;
            sl = (fa < 0) ? int'($urandom % 4) : 0;
            do_op(r, $urandom % 4, $urandom % 4, sl, fa, $urandom);
        end

        @(posedge clock); #1;
        drive_idle();
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("drain", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
